// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM states, row geometry
// and the mapping from a row number to its truth-table bit.
package sweep_pkg;

  localparam int unsigned N_IN   = 3;
  localparam int unsigned N_ROWS = 8;
  localparam int unsigned ROW_W  = $clog2(N_ROWS);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Row 0 lands in the MSB of the table, row 7 in the LSB.
  function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] r);
    return ROW_W'(N_ROWS - 1) - r;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all rows of a 3-input netlist, samples its synchronised output per row,
// and reports the observed truth table against an expected code.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter logic [N_ROWS-1:0] EXPECTED      = 8'h16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] truth_table,
  output logic              pass,
  output logic [N_ROWS-1:0] mismatch
);

  localparam int unsigned      CNT_W    = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

  // Fewer than 3 settle cycles leaves no time for the netlist after sync latency.
  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("truth_table_sweeper: SETTLE_CYCLES must be at least 3");
  end

  state_t            state;
  logic [ROW_W-1:0]  row;
  logic [CNT_W-1:0]  cnt;
  logic              dut_sync;
  logic [N_ROWS-1:0] table_upd;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dut_out),
    .q   (dut_sync)
  );

  // Table with the current row's sample merged in; committed on the SAMPLE edge.
  always_comb begin
    table_upd                = truth_table;
    table_upd[row_bit(row)]  = dut_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row           <= '0;
      cnt           <= '0;
      {in1,in2,in3} <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      truth_table   <= '0;
      pass          <= 1'b0;
      mismatch      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state         <= SETTLE;
            row           <= '0;
            cnt           <= CNT_LOAD;
            {in1,in2,in3} <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            truth_table   <= '0;
            pass          <= 1'b0;
            mismatch      <= '0;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        SAMPLE: begin
          truth_table <= table_upd;
          if (row == LAST_ROW) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass     <= (table_upd == EXPECTED);
            mismatch <= table_upd ^ EXPECTED;
          end else begin
            state         <= SETTLE;
            row           <= row + ROW_W'(1);
            {in1,in2,in3} <= row + ROW_W'(1);
            cnt           <= CNT_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
